// File: rtl/wb_pkg.sv
// Shared types for the writeback / common-data-bus path: source ids, the
// default-width result entry, and the round-robin successor helper.
package wb_pkg;

  // Number of completion sources sharing the single result write port.
  localparam int WB_NUM_SRC = 3;

  // Default widths of the result fields; the arbiter parameters default to these.
  localparam int WB_DATA_W = 32;
  localparam int WB_PHY_W  = 6;
  localparam int WB_ROB_W  = 5;

  // Completion source identifiers, also driven out on cdb_src.
  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_LOAD   = 2'd1,
    SRC_BRANCH = 2'd2
  } wb_src_e;

  // One completed result at default widths, as seen by PRF/ROB consumers.
  typedef struct packed {
    logic [WB_ROB_W-1:0]  rob_id;
    logic [WB_PHY_W-1:0]  rd_phy;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Next source in the fixed rotation ALU -> LOAD -> BRANCH -> ALU.
  // The unused encoding folds back to ALU so the pointer can never stick.
  function automatic wb_src_e wb_next_src(input wb_src_e s);
    case (s)
      SRC_ALU:  return SRC_LOAD;
      SRC_LOAD: return SRC_BRANCH;
      default:  return SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO. Push is ignored when full, pop is ignored when
// empty, and a synchronous flush empties the queue and discards any push or
// pop requested in the same cycle. The head entry is presented combinationally.
module wb_src_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Qualified operations: flush overrides both, and the full/empty guards
  // keep the pointers consistent even if the caller misbehaves.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  assign full  = (count == CNT_DEPTH);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: ALU, load and branch results queue in per-source FIFOs
// and a round-robin arbiter moves one head per cycle onto a registered
// common data bus feeding the PRF write port and ROB completion.
//
// Handshake: a source transfer happens at a rising edge where x_valid and
// x_ready are both 1 (and flush is 0). x_ready depends only on the FIFO
// occupancy, never on x_valid, and there is no same-cycle pass-through: a
// full FIFO stays not-ready even in a cycle where its head is being granted.
// The CDB side has no backpressure; cdb_valid is high for exactly one cycle
// per granted entry and the data fields hold their last value when idle.
module wb_cdb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int PHY_WIDTH  = WB_PHY_W,
  parameter int ROB_WIDTH  = WB_ROB_W,
  parameter int Q_DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,

  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ROB_WIDTH-1:0]  alu_rob_id,
  input  logic [PHY_WIDTH-1:0]  alu_rd_phy,
  input  logic [DATA_WIDTH-1:0] alu_data,

  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ROB_WIDTH-1:0]  ld_rob_id,
  input  logic [PHY_WIDTH-1:0]  ld_rd_phy,
  input  logic [DATA_WIDTH-1:0] ld_data,

  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [ROB_WIDTH-1:0]  br_rob_id,
  input  logic [PHY_WIDTH-1:0]  br_rd_phy,
  input  logic [DATA_WIDTH-1:0] br_data,

  output logic                  cdb_valid,
  output logic [1:0]            cdb_src,
  output logic [ROB_WIDTH-1:0]  cdb_rob_id,
  output logic [PHY_WIDTH-1:0]  cdb_rd_phy,
  output logic [DATA_WIDTH-1:0] cdb_data,

  output logic [1:0]            dbg_rr_ptr
);

  localparam int ENTRY_W = ROB_WIDTH + PHY_WIDTH + DATA_WIDTH;

  // Result entry at this instance's widths (same field order as wb_entry_t).
  typedef struct packed {
    logic [ROB_WIDTH-1:0]  rob_id;
    logic [PHY_WIDTH-1:0]  rd_phy;
    logic [DATA_WIDTH-1:0] data;
  } cdb_entry_t;

  cdb_entry_t             in_e   [WB_NUM_SRC];
  cdb_entry_t             head_e [WB_NUM_SRC];
  logic [WB_NUM_SRC-1:0]  src_valid;
  logic [WB_NUM_SRC-1:0]  full_v;
  logic [WB_NUM_SRC-1:0]  empty_v;
  logic [WB_NUM_SRC-1:0]  push_v;
  logic [WB_NUM_SRC-1:0]  pop_v;

  wb_src_e    rr_ptr;
  wb_src_e    cand0;
  wb_src_e    cand1;
  wb_src_e    cand2;
  logic       gnt_valid;
  wb_src_e    gnt_src;
  cdb_entry_t gnt_entry;

  logic       cdb_valid_q;
  wb_src_e    cdb_src_q;
  cdb_entry_t cdb_entry_q;

  // Source-side packing, indexed by wb_src_e.
  assign in_e[SRC_ALU]    = '{rob_id: alu_rob_id, rd_phy: alu_rd_phy, data: alu_data};
  assign in_e[SRC_LOAD]   = '{rob_id: ld_rob_id,  rd_phy: ld_rd_phy,  data: ld_data};
  assign in_e[SRC_BRANCH] = '{rob_id: br_rob_id,  rd_phy: br_rd_phy,  data: br_data};

  assign src_valid = {br_valid, ld_valid, alu_valid};

  // A push is requested only when the FIFO can take it; the FIFO itself
  // drops the push on flush.
  assign push_v = src_valid & ~full_v;

  assign alu_ready = ~full_v[SRC_ALU];
  assign ld_ready  = ~full_v[SRC_LOAD];
  assign br_ready  = ~full_v[SRC_BRANCH];

  for (genvar g = 0; g < WB_NUM_SRC; g++) begin : g_src
    wb_src_fifo #(
      .W     (ENTRY_W),
      .DEPTH (Q_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push_v[g]),
      .pop   (pop_v[g]),
      .din   (in_e[g]),
      .full  (full_v[g]),
      .empty (empty_v[g]),
      .head  (head_e[g])
    );
  end

  // Search order for this cycle, starting at the round-robin pointer.
  assign cand0 = rr_ptr;
  assign cand1 = wb_next_src(cand0);
  assign cand2 = wb_next_src(cand1);

  // Pick the first non-empty FIFO in search order and pop its head.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = rr_ptr;
    if (!empty_v[cand0]) begin
      gnt_valid = 1'b1;
      gnt_src   = cand0;
    end else if (!empty_v[cand1]) begin
      gnt_valid = 1'b1;
      gnt_src   = cand1;
    end else if (!empty_v[cand2]) begin
      gnt_valid = 1'b1;
      gnt_src   = cand2;
    end
    pop_v = '0;
    if (gnt_valid) pop_v[gnt_src] = 1'b1;
    gnt_entry = head_e[gnt_src];
  end

  // CDB output register and round-robin pointer. Flush suppresses the grant
  // and leaves the pointer where it was; an idle cycle only clears cdb_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= SRC_ALU;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= SRC_ALU;
      cdb_entry_q <= '0;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
    end else if (gnt_valid) begin
      rr_ptr      <= wb_next_src(gnt_src);
      cdb_valid_q <= 1'b1;
      cdb_src_q   <= gnt_src;
      cdb_entry_q <= gnt_entry;
    end else begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_src    = cdb_src_q;
  assign cdb_rob_id = cdb_entry_q.rob_id;
  assign cdb_rd_phy = cdb_entry_q.rd_phy;
  assign cdb_data   = cdb_entry_q.data;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Directed bench for wb_cdb_arbiter: reset, single result, round-robin order,
// backpressure, flush and asynchronous reset in the middle of traffic.
module tb_wb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alu_valid, ld_valid, br_valid;
  logic        alu_ready, ld_ready, br_ready;
  logic [4:0]  alu_rob_id, ld_rob_id, br_rob_id;
  logic [5:0]  alu_rd_phy, ld_rd_phy, br_rd_phy;
  logic [31:0] alu_data, ld_data, br_data;
  logic        cdb_valid;
  logic [1:0]  cdb_src;
  logic [4:0]  cdb_rob_id;
  logic [5:0]  cdb_rd_phy;
  logic [31:0] cdb_data;
  logic [1:0]  dbg_rr_ptr;

  int errors = 0;
  int checks = 0;

  wb_cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rob_id (alu_rob_id),
    .alu_rd_phy (alu_rd_phy),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rob_id  (ld_rob_id),
    .ld_rd_phy  (ld_rd_phy),
    .ld_data    (ld_data),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_rob_id  (br_rob_id),
    .br_rd_phy  (br_rd_phy),
    .br_data    (br_data),
    .cdb_valid  (cdb_valid),
    .cdb_src    (cdb_src),
    .cdb_rob_id (cdb_rob_id),
    .cdb_rd_phy (cdb_rd_phy),
    .cdb_data   (cdb_data),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    br_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] rob, input logic [5:0] phy, input logic [31:0] d);
    alu_valid = 1'b1; alu_rob_id = rob; alu_rd_phy = phy; alu_data = d;
  endtask

  task automatic drive_ld(input logic [4:0] rob, input logic [5:0] phy, input logic [31:0] d);
    ld_valid = 1'b1; ld_rob_id = rob; ld_rd_phy = phy; ld_data = d;
  endtask

  task automatic drive_br(input logic [4:0] rob, input logic [5:0] phy, input logic [31:0] d);
    br_valid = 1'b1; br_rob_id = rob; br_rd_phy = phy; br_data = d;
  endtask

  // Hand-derived backpressure schedule: ALU and BR offer on cycles 1-6,
  // LOAD on cycles 1-4, each holding its payload until accepted.
  logic [1:0]  exp_src4 [10] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  logic [31:0] exp_dat4 [10] = '{32'hA000_0000, 32'hB000_0000, 32'hC000_0000,
                                 32'hA000_0001, 32'hB000_0001, 32'hC000_0001,
                                 32'hA000_0002, 32'hB000_0002, 32'hC000_0002,
                                 32'hA000_0003};
  logic        exp_alur [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        exp_ldr  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        exp_brr  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int ai, li, bi;
    bit acc_a, acc_l, acc_b;

    rst = 1'b0;
    idle_inputs();
    alu_rob_id = '0; alu_rd_phy = '0; alu_data = '0;
    ld_rob_id  = '0; ld_rd_phy  = '0; ld_data  = '0;
    br_rob_id  = '0; br_rd_phy  = '0; br_data  = '0;

    // 1: reset held with random traffic on the inputs.
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'($urandom_range(0, 1));
      ld_valid  = 1'($urandom_range(0, 1));
      br_valid  = 1'($urandom_range(0, 1));
      alu_data  = $urandom;
      ld_data   = $urandom;
      br_data   = $urandom;
      flush     = 1'($urandom_range(0, 1));
      tick();
      check("rst_cdb_valid", cdb_valid, 0);
    end
    check("rst_rr_ptr", dbg_rr_ptr, 0);
    check("rst_cdb_data", cdb_data, 0);
    check("rst_cdb_rob", cdb_rob_id, 0);
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_alu_ready", alu_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_br_ready", br_ready, 1);
    tick();
    check("rst_idle_cdb_valid", cdb_valid, 0);

    // 2: single ALU result.
    drive_alu(5'd3, 6'd7, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    check("single_accept_cycle", cdb_valid, 0);
    tick();
    check("single_valid", cdb_valid, 1);
    check("single_src", cdb_src, 0);
    check("single_rob", cdb_rob_id, 3);
    check("single_phy", cdb_rd_phy, 7);
    check("single_data", cdb_data, 32'hDEAD_BEEF);
    check("single_rr", dbg_rr_ptr, 1);
    tick();
    check("single_drop", cdb_valid, 0);
    check("single_hold", cdb_data, 32'hDEAD_BEEF);

    // 3: branch alone (pointer at LOAD skips the empty LOAD FIFO), then two
    //    rounds of simultaneous pushes from all sources.
    drive_br(5'd1, 6'd2, 32'h0000_0B01);
    tick();
    idle_inputs();
    tick();
    check("br_only_src", cdb_src, 2);
    check("br_only_data", cdb_data, 32'h0000_0B01);
    check("br_only_rr", dbg_rr_ptr, 0);
    for (int r = 0; r < 2; r++) begin
      drive_alu(5'(4 + r), 6'(10 + r), 32'h1111_1111 * 32'(1 + 3*r));
      drive_ld (5'(6 + r), 6'(20 + r), 32'h1111_1111 * 32'(2 + 3*r));
      drive_br (5'(8 + r), 6'(30 + r), 32'h1111_1111 * 32'(3 + 3*r));
      tick();
      idle_inputs();
      check("rr_push_idle", cdb_valid, 0);
      tick();
      check("rr_g1_src", cdb_src, 0);
      check("rr_g1_data", cdb_data, 32'h1111_1111 * 32'(1 + 3*r));
      check("rr_g1_rob", cdb_rob_id, 5'(4 + r));
      tick();
      check("rr_g2_src", cdb_src, 1);
      check("rr_g2_data", cdb_data, 32'h1111_1111 * 32'(2 + 3*r));
      check("rr_g2_phy", cdb_rd_phy, 6'(20 + r));
      tick();
      check("rr_g3_valid", cdb_valid, 1);
      check("rr_g3_src", cdb_src, 2);
      check("rr_g3_data", cdb_data, 32'h1111_1111 * 32'(3 + 3*r));
      check("rr_after_rr", dbg_rr_ptr, 0);
    end

    // 4: backpressure with ALU and BR saturating.
    ai = 0; li = 0; bi = 0;
    for (int c = 1; c <= 12; c++) begin
      alu_valid = (c <= 6);
      alu_rob_id = 5'(ai); alu_rd_phy = 6'(ai); alu_data = 32'hA000_0000 + 32'(ai);
      ld_valid  = (c <= 4);
      ld_rob_id = 5'(8 + li); ld_rd_phy = 6'(8 + li); ld_data = 32'hB000_0000 + 32'(li);
      br_valid  = (c <= 6);
      br_rob_id = 5'(16 + bi); br_rd_phy = 6'(16 + bi); br_data = 32'hC000_0000 + 32'(bi);
      acc_a = alu_valid && alu_ready;
      acc_l = ld_valid && ld_ready;
      acc_b = br_valid && br_ready;
      tick();
      if (acc_a) ai++;
      if (acc_l) li++;
      if (acc_b) bi++;
      if (c <= 6) begin
        check($sformatf("bp_alu_ready_c%0d", c), alu_ready, exp_alur[c-1]);
        check($sformatf("bp_ld_ready_c%0d", c), ld_ready, exp_ldr[c-1]);
        check($sformatf("bp_br_ready_c%0d", c), br_ready, exp_brr[c-1]);
      end
      if (c == 1 || c == 12) begin
        check($sformatf("bp_idle_c%0d", c), cdb_valid, 0);
      end else begin
        check($sformatf("bp_valid_c%0d", c), cdb_valid, 1);
        check($sformatf("bp_src_c%0d", c), cdb_src, exp_src4[c-2]);
        check($sformatf("bp_data_c%0d", c), cdb_data, exp_dat4[c-2]);
      end
    end
    idle_inputs();
    check("bp_alu_accepted", ai, 4);
    check("bp_ld_accepted", li, 3);
    check("bp_br_accepted", bi, 3);
    check("bp_rr_end", dbg_rr_ptr, 1);

    // 5: flush with entries queued and a new ALU result offered.
    for (int r = 0; r < 2; r++) begin
      drive_alu(5'(20 + r), 6'(40 + r), 32'hE000_0000 + 32'(r));
      drive_ld (5'(22 + r), 6'(42 + r), 32'hE100_0000 + 32'(r));
      drive_br (5'(24 + r), 6'(44 + r), 32'hE200_0000 + 32'(r));
      tick();
    end
    idle_inputs();
    check("fl_pre_src", cdb_src, 1);
    check("fl_pre_data", cdb_data, 32'hE100_0000);
    check("fl_pre_rr", dbg_rr_ptr, 2);
    flush = 1'b1;
    drive_alu(5'd31, 6'd63, 32'hF1F1_F1F1);
    tick();
    idle_inputs();
    check("fl_cdb_valid", cdb_valid, 0);
    check("fl_rr_kept", dbg_rr_ptr, 2);
    check("fl_alu_ready", alu_ready, 1);
    check("fl_ld_ready", ld_ready, 1);
    check("fl_br_ready", br_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_quiet_valid", cdb_valid, 0);
      check("fl_quiet_data", cdb_data, 32'hE100_0000);
    end

    // 6: asynchronous reset between edges while cdb_valid is high.
    drive_alu(5'd9, 6'd9, 32'h0A0A_0A0A);
    drive_ld (5'd10, 6'd10, 32'h0B0B_0B0B);
    tick();
    idle_inputs();
    tick();
    check("ar_pre_valid", cdb_valid, 1);
    check("ar_pre_src", cdb_src, 0);
    check("ar_pre_data", cdb_data, 32'h0A0A_0A0A);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid_now", cdb_valid, 0);
    check("ar_data_now", cdb_data, 0);
    check("ar_rr_now", dbg_rr_ptr, 0);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_queue_empty", cdb_valid, 0);
    end
    check("ar_ld_ready", ld_ready, 1);
    check("ar_alu_ready", alu_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
